// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage running one req/ack bus transaction at a time.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_mem_enable_i,
   input  logic [31:0] r_mem_addr_i,
   input  logic        w_mem_enable_i,
   input  logic [31:0] w_mem_addr_i,
   input  logic [31:0] w_mem_data_i,
   input  logic [2:0]  data_type_i,
   input  logic        mem_w_reg_enable_i,
   input  logic [4:0]  w_reg_addr_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stall_o,
   output logic        mem_w_reg_enable_o,
   output logic [4:0]  w_reg_addr_o,
   output logic [31:0] mem_w_reg_data_o,
   output logic        bus_err_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  type_q;
   logic        we_q, reg_en_q, err_q, mis_q;
   logic [4:0]  rd_q;
   logic [15:0] cnt_q;

   logic        req_in, mis_d, timeout;
   logic [31:0] addr_in;
   logic [3:0]  st_be;
   logic [31:0] st_data, ld_data;
   logic [7:0]  lane8;
   logic [15:0] lane16;

   assign req_in  = (w_mem_enable_i | r_mem_enable_i)
                  & (data_type_i != 3'd0);
   assign addr_in = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
   assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis_d = ((data_type_i[1:0] == 2'b10) & addr_in[0])
                | ((data_type_i[1:0] == 2'b11) & (addr_in[1:0] != 2'b00));
`else
   assign mis_d = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: accept in IDLE, wait for ack/timeout in REQ, one DONE cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_in) state_d = mis_d ? DONE : REQ;
         REQ:     if (bus_ack_i | timeout) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the request, count REQ cycles, capture read data or the error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         type_q   <= '0;
         we_q     <= 1'b0;
         reg_en_q <= 1'b0;
         err_q    <= 1'b0;
         mis_q    <= 1'b0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (req_in) begin
               addr_q   <= addr_in;
               wdata_q  <= w_mem_data_i;
               type_q   <= data_type_i;
               we_q     <= w_mem_enable_i;
               reg_en_q <= mem_w_reg_enable_i;
               rd_q     <= w_reg_addr_i;
               mis_q    <= mis_d;
               err_q    <= 1'b0;
               cnt_q    <= '0;
            end
            REQ: begin
               cnt_q <= cnt_q + 16'd1;
               if (bus_ack_i)    rdata_q <= bus_rdata_i;
               else if (timeout) err_q   <= 1'b1;
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   // Store lane steering: strobes and replicated data from the latched access.
   always_comb begin
      unique case (type_q[1:0])
         2'b01: begin
            st_be   = 4'b0001 << addr_q[1:0];
            st_data = {4{wdata_q[7:0]}};
         end
         2'b10: begin
            st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_q[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = wdata_q;
         end
      endcase
   end

   // Load extraction with sign extension for types 1/2, zero for 5/6.
   always_comb begin
      lane8  = rdata_q[{addr_q[1:0], 3'b000} +: 8];
      lane16 = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      unique case (type_q[1:0])
         2'b01:   ld_data = {{24{~type_q[2] & lane8[7]}}, lane8};
         2'b10:   ld_data = {{16{~type_q[2] & lane16[15]}}, lane16};
         default: ld_data = rdata_q;
      endcase
   end

   // Outputs decoded from state; anything inactive is held at 0.
   always_comb begin
      stall_o            = 1'b0;
      bus_req_o          = 1'b0;
      bus_we_o           = 1'b0;
      bus_addr_o         = '0;
      bus_wdata_o        = '0;
      bus_be_o           = '0;
      mem_w_reg_enable_o = 1'b0;
      w_reg_addr_o       = '0;
      mem_w_reg_data_o   = '0;
      bus_err_o          = 1'b0;
      misalign_o         = 1'b0;
      unique case (state_q)
         IDLE: stall_o = req_in;
         REQ: begin
            stall_o     = 1'b1;
            bus_req_o   = 1'b1;
            bus_we_o    = we_q;
            bus_addr_o  = {addr_q[31:2], 2'b00};
            bus_wdata_o = we_q ? st_data : '0;
            bus_be_o    = we_q ? st_be : 4'b1111;
         end
         DONE: begin
            if (err_q) begin
               bus_err_o = 1'b1;
            end else if (~we_q & reg_en_q & ~mis_q) begin
               mem_w_reg_enable_o = 1'b1;
               w_reg_addr_o       = rd_q;
               mem_w_reg_data_o   = ld_data;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o = mis_q;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with TIMEOUT_CYCLES = 4.
// Misalignment expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        r_mem_enable_i, w_mem_enable_i;
   logic [31:0] r_mem_addr_i, w_mem_addr_i, w_mem_data_i;
   logic [2:0]  data_type_i;
   logic        mem_w_reg_enable_i;
   logic [4:0]  w_reg_addr_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        stall_o, mem_w_reg_enable_o;
   logic [4:0]  w_reg_addr_o;
   logic [31:0] mem_w_reg_data_o;
   logic        bus_err_o, misalign_o;

   int total = 0;
   int bad   = 0;

   mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .r_mem_enable_i(r_mem_enable_i), .r_mem_addr_i(r_mem_addr_i),
      .w_mem_enable_i(w_mem_enable_i), .w_mem_addr_i(w_mem_addr_i),
      .w_mem_data_i(w_mem_data_i), .data_type_i(data_type_i),
      .mem_w_reg_enable_i(mem_w_reg_enable_i), .w_reg_addr_i(w_reg_addr_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .stall_o(stall_o), .mem_w_reg_enable_o(mem_w_reg_enable_o),
      .w_reg_addr_o(w_reg_addr_o), .mem_w_reg_data_o(mem_w_reg_data_o),
      .bus_err_o(bus_err_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      r_mem_enable_i     = 1'b0;
      w_mem_enable_i     = 1'b0;
      r_mem_addr_i       = '0;
      w_mem_addr_i       = '0;
      w_mem_data_i       = '0;
      data_type_i        = '0;
      mem_w_reg_enable_i = 1'b0;
      w_reg_addr_i       = '0;
   endtask

   // Present a request in IDLE, check the same-cycle stall, accept it.
   task automatic issue(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] t,
                        input logic [4:0] r);
      w_mem_enable_i     = we;
      r_mem_enable_i     = 1'b1;
      w_mem_addr_i       = a;
      r_mem_addr_i       = a;
      w_mem_data_i       = d;
      data_type_i        = t;
      mem_w_reg_enable_i = ~we;
      w_reg_addr_i       = r;
      #1;
      chk("stall_accept", stall_o, 1'b1);
      chk("req_accept", bus_req_o, 1'b0);
      tick();
      clear_in();
   endtask

   // Hold REQ for nwait cycles, then ack and check the bus fields.
   task automatic req_phase(input int nwait, input logic [31:0] rd,
                            input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
      for (int i = 0; i < nwait; i++) begin
         chk("req_wait", bus_req_o, 1'b1);
         tick();
      end
      bus_ack_i   = 1'b1;
      bus_rdata_i = rd;
      #1;
      chk("bus_req", bus_req_o, 1'b1);
      chk("bus_we", bus_we_o, we);
      chk("bus_addr", bus_addr_o, a);
      chk("bus_be", bus_be_o, be);
      chk("bus_wdata", bus_wdata_o, wd);
      chk("stall_req", stall_o, 1'b1);
      tick();
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
   endtask

   // Check the single DONE cycle, then step back to IDLE.
   task automatic done_chk(input logic wb, input logic [4:0] r,
                           input logic [31:0] d, input logic err);
      chk("done_stall", stall_o, 1'b0);
      chk("done_req", bus_req_o, 1'b0);
      chk("wb_en", mem_w_reg_enable_o, wb);
      chk("wb_addr", w_reg_addr_o, r);
      chk("wb_data", mem_w_reg_data_o, d);
      chk("bus_err", bus_err_o, err);
      tick();
      chk("wb_en_after", mem_w_reg_enable_o, 1'b0);
      chk("err_after", bus_err_o, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      clear_in();
      #2;
      chk("rst_req", bus_req_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_wb", mem_w_reg_enable_o, 1'b0);
      chk("rst_err", bus_err_o, 1'b0);
      chk("rst_mis", misalign_o, 1'b0);
      chk("rst_addr", bus_addr_o, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Word load, ack in first REQ cycle.
      issue(1'b0, 32'h100, 32'h0, 3'd3, 5'd5);
      req_phase(0, 32'hDEADBEEF, 1'b0, 32'h100, 4'hF, 32'h0);
      done_chk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);

      // Signed and unsigned byte load from lane 3.
      issue(1'b0, 32'h103, 32'h0, 3'd1, 5'd7);
      req_phase(0, 32'h80123456, 1'b0, 32'h100, 4'hF, 32'h0);
      done_chk(1'b1, 5'd7, 32'hFFFFFF80, 1'b0);
      issue(1'b0, 32'h103, 32'h0, 3'd5, 5'd7);
      req_phase(0, 32'h80123456, 1'b0, 32'h100, 4'hF, 32'h0);
      done_chk(1'b1, 5'd7, 32'h00000080, 1'b0);

      // Byte store at 0x202, ack on the third REQ cycle.
      issue(1'b1, 32'h202, 32'h000000A5, 3'd1, 5'd0);
      req_phase(2, 32'h0, 1'b1, 32'h200, 4'b0100, 32'hA5A5A5A5);
      done_chk(1'b0, 5'd0, 32'h0, 1'b0);

      // Half store and half-unsigned load at 0x302.
      issue(1'b1, 32'h302, 32'h00001234, 3'd2, 5'd0);
      req_phase(0, 32'h0, 1'b1, 32'h300, 4'b1100, 32'h12341234);
      done_chk(1'b0, 5'd0, 32'h0, 1'b0);
      issue(1'b0, 32'h302, 32'h0, 3'd6, 5'd9);
      req_phase(1, 32'hBEEF0000, 1'b0, 32'h300, 4'hF, 32'h0);
      done_chk(1'b1, 5'd9, 32'h0000BEEF, 1'b0);

      // Signed half load from the low lane.
      issue(1'b0, 32'h400, 32'h0, 3'd2, 5'd3);
      req_phase(0, 32'h00008001, 1'b0, 32'h400, 4'hF, 32'h0);
      done_chk(1'b1, 5'd3, 32'hFFFF8001, 1'b0);

      // Timeout: four REQ cycles with no ack, then an error pulse.
      issue(1'b0, 32'h500, 32'h0, 3'd3, 5'd4);
      for (int i = 0; i < 4; i++) begin
         chk("to_req", bus_req_o, 1'b1);
         tick();
      end
      done_chk(1'b0, 5'd0, 32'h0, 1'b1);

      // Ack on the limit cycle wins over the timeout.
      issue(1'b0, 32'h504, 32'h0, 3'd3, 5'd6);
      req_phase(3, 32'h13572468, 1'b0, 32'h504, 4'hF, 32'h0);
      done_chk(1'b1, 5'd6, 32'h13572468, 1'b0);

      // A type-0 request is ignored.
      r_mem_enable_i = 1'b1;
      r_mem_addr_i   = 32'h600;
      #1;
      chk("none_stall", stall_o, 1'b0);
      tick();
      chk("none_req", bus_req_o, 1'b0);
      clear_in();
      tick();

      // Reset in the middle of REQ abandons the access.
      issue(1'b0, 32'h700, 32'h0, 3'd3, 5'd8);
      chk("mid_req", bus_req_o, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mid_req", bus_req_o, 1'b0);
      chk("rst_mid_stall", stall_o, 1'b0);
      chk("rst_mid_addr", bus_addr_o, 32'h0);
      tick();
      chk("rst_mid_wb", mem_w_reg_enable_o, 1'b0);
      rst = 1'b0;
      tick();
      chk("post_rst_req", bus_req_o, 1'b0);
      chk("post_rst_wb", mem_w_reg_enable_o, 1'b0);

      // Misaligned word load at 0x101.
`ifdef MEM_MISALIGN_TRAP_EN
      issue(1'b0, 32'h101, 32'h0, 3'd3, 5'd2);
      chk("mis_req", bus_req_o, 1'b0);
      chk("mis_stall", stall_o, 1'b0);
      chk("mis_pulse", misalign_o, 1'b1);
      chk("mis_wb", mem_w_reg_enable_o, 1'b0);
      tick();
      chk("mis_after", misalign_o, 1'b0);
`else
      issue(1'b0, 32'h101, 32'h0, 3'd3, 5'd2);
      req_phase(0, 32'h11223344, 1'b0, 32'h100, 4'hF, 32'h0);
      chk("mis_off", misalign_o, 1'b0);
      done_chk(1'b1, 5'd2, 32'h11223344, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes execute's load/store request: addresses, enables, store data, data type, and load destination register.
- Runs one transaction at a time on a req/ack data bus, stalling the pipeline while it is in flight.
- Stores: generates byte strobes and replicates store data. Loads: extracts and sign/zero-extends the data, then presents the register writeback.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ without bus_ack_i before the access is aborted with bus_err_o (legal range 1..65535).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- r_mem_enable_i  in  1  read request from execute.
- r_mem_addr_i  in  32  load byte address.
- w_mem_enable_i  in  1  write request from execute; has priority over r_mem_enable_i (execute asserts both for stores).
- w_mem_addr_i  in  32  store byte address.
- w_mem_data_i  in  32  store data, low-aligned.
- data_type_i  in  3  0 none, 1 byte, 2 half, 3 word, 5 byte-unsigned, 6 half-unsigned.
- mem_w_reg_enable_i  in  1  load writes a register.
- w_reg_addr_i  in  5  load destination register.
- bus_req_o  out  1  bus request; held until ack or timeout.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata_o  out  32  lane-replicated store data.
- bus_be_o  out  4  byte strobes.
- bus_ack_i  in  1  transaction complete; bus_rdata_i valid in the same cycle.
- bus_rdata_i  in  32  read data.
- stall_o  out  1  hold upstream pipeline.
- mem_w_reg_enable_o  out  1  one-cycle load writeback strobe.
- w_reg_addr_o  out  5  writeback register.
- mem_w_reg_data_o  out  32  extended load data.
- bus_err_o  out  1  one-cycle timeout pulse.
- misalign_o  out  1  one-cycle misalignment pulse (Optional Feature).

Behaviour:
- Reset: asynchronous, active-high. State = IDLE; all outputs 0; timeout counter 0. Asserting rst mid-transaction drops bus_req_o immediately; the transaction is abandoned with no writeback.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Request = w_mem_enable_i | r_mem_enable_i. On request, stall_o = 1 combinationally in the same cycle.
  - Latch addr (from w_ or r_mem_addr_i), data, data_type, is-write, reg addr and reg-enable; go to REQ.
  - A request with data_type_i = 0 is ignored.
- REQ:
  - bus_req_o = 1; bus_* driven from latched values; stall_o = 1; counter increments every cycle.
  - On bus_ack_i: capture bus_rdata_i and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES without ack: go to DONE with an error flag.
  - Ack in the same cycle the limit is reached: ack wins.
- DONE (exactly one cycle):
  - stall_o = 0.
  - Load without error and with latched reg-enable: mem_w_reg_enable_o = 1, w_reg_addr_o / mem_w_reg_data_o valid.
  - Error: bus_err_o = 1, no writeback.
  - Next state IDLE. No new request is accepted in DONE; a request present then is taken in the following IDLE cycle.
- Latency: minimum 3 cycles from request to writeback (accept, REQ with ack, DONE), i.e. stall_o high for 2 cycles.
- Store lane steering (o = addr[1:0]):
  - byte: be = 4'b0001 << o; wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - word: be = 4'b1111; wdata = data.
- Loads: bus_be_o = 4'b1111 (the strobes above are store-only).
- Load extraction:
  - byte = rdata[8*o +: 8]; half = rdata[16*addr[1] +: 16].
  - Types 1 and 2 sign-extend; types 5 and 6 zero-extend; word passes through.
- Outputs not active in the current state are driven 0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned = half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned access goes IDLE -> DONE with no bus_req_o; DONE asserts misalign_o for one cycle; no writeback; stall_o high for 1 cycle.
- Undefined: misalign_o tied 0; addr[0] (half) or addr[1:0] (word) is ignored for lane selection, and the access proceeds aligned.

Test Plan:
- Word load addr 0x100, data_type 3, reg 5; ack in first REQ cycle with rdata 0xDEADBEEF -> bus_addr_o 0x100, be 1111, stall_o 2 cycles, then mem_w_reg_enable_o 1 cycle, w_reg_addr_o 5, data 0xDEADBEEF.
- Byte load addr 0x103, type 1, rdata 0x80xxxxxx -> data 0xFFFFFF80; same access with type 5 -> 0x00000080.
- Store byte 0xA5 at addr 0x202, ack after 3 cycles -> bus_we_o 1, bus_addr_o 0x200, be 0100, wdata 0xA5A5A5A5, no writeback.
- Half store 0x1234 at 0x302 -> be 1100, wdata 0x12341234; half-unsigned load at 0x302 with rdata 0xBEEF0000 -> data 0x0000BEEF.
- TIMEOUT_CYCLES = 4, no ack -> bus_req_o high 4 cycles then low; bus_err_o pulses 1 cycle; no writeback. Separately, rst asserted mid-REQ -> bus_req_o low immediately, all outputs 0.
- With MEM_MISALIGN_TRAP_EN: word load at 0x101 -> no bus_req_o, misalign_o pulse, stall_o 1 cycle. Without the macro: same load reads word 0x100.
